// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESPOND
  } icache_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int off_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_bits(input int lines, input int line_words);
    return 32 - off_bits(line_words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the instruction cache: combinational read port,
// one word write port, tag/valid write and a single-cycle invalidate-all.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int TW         = tag_bits(LINES, LINE_WORDS),
  parameter int IW         = $clog2(LINES),
  parameter int WW         = $clog2(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush_all,
  input  logic [IW-1:0] i_rd_idx,
  input  logic [WW-1:0] i_rd_word,
  output logic          o_rd_valid,
  output logic [TW-1:0] o_rd_tag,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [WW-1:0] i_wr_word,
  input  logic [31:0]   i_wr_data,
  input  logic          i_tag_we,
  input  logic [TW-1:0] i_tag_wdata,
  input  logic          i_set_valid
);

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];

  // NOTE: tag and data arrays have no reset; a line's contents only matter once its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_wr_en)  r_data[i_wr_idx][i_wr_word] <= i_wr_data;
    if (i_tag_we) r_tag[i_wr_idx]             <= i_tag_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush_all) begin
      r_valid <= '0;
    end else if (i_tag_we && i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: single outstanding fetch request,
// whole-line refill from a word-wide memory port, hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ready,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        cache_ack,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WW  = $clog2(LINE_WORDS);
  localparam int IW  = $clog2(LINES);
  localparam int OFF = off_bits(LINE_WORDS);
  localparam int TW  = tag_bits(LINES, LINE_WORDS);
  localparam logic [WW-1:0] LAST = WW'(LINE_WORDS - 1);

  icache_state_t r_state;
  logic [31:2]   r_req_addr;
  logic [WW-1:0] r_cnt;
  logic [31:0]   r_resp;
  logic [31:0]   r_inst;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_hit_count;
  logic [31:0]   r_miss_count;
  logic          r_ack;
  logic          r_mem_req;
  logic          r_flush_pend;

  logic          w_rd_valid;
  logic [TW-1:0] w_rd_tag;
  logic [31:0]   w_rd_data;
  logic          w_hit;
  logic [IW-1:0] w_line_idx;
  logic [WW-1:0] w_req_word;
  logic [WW-1:0] w_next_cnt;
  logic          w_fill;
  logic          w_last;
  logic          w_crit;
  logic          w_unused;

  // The lookup is done in the request cycle so the hit ack can be registered into LOOKUP.
  assign w_hit      = w_rd_valid && (w_rd_tag == addr[31:OFF+IW]) && !flush;
  assign w_line_idx = r_req_addr[OFF+IW-1:OFF];
  assign w_req_word = r_req_addr[OFF-1:2];
  assign w_next_cnt = r_cnt + WW'(1);
  assign w_fill     = (r_state == REFILL) && mem_ack;
  assign w_last     = w_fill && (r_cnt == LAST);
  assign w_crit     = (w_req_word == r_cnt);
  assign w_unused   = ^addr[1:0];

  icache_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TW         (TW)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_flush_all (flush),
    .i_rd_idx    (addr[OFF+IW-1:OFF]),
    .i_rd_word   (addr[OFF-1:2]),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_fill),
    .i_wr_idx    (w_line_idx),
    .i_wr_word   (r_cnt),
    .i_wr_data   (mem_rdata),
    .i_tag_we    (w_last),
    .i_tag_wdata (r_req_addr[31:OFF+IW]),
    .i_set_valid (!(r_flush_pend || flush))
  );

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_addr   <= '0;
      r_cnt        <= '0;
      r_resp       <= NOP;
      r_inst       <= NOP;
      r_ack        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (addr_ready) begin
            r_req_addr <= addr[31:2];
            r_state    <= LOOKUP;
            if (w_hit) begin
              r_ack       <= 1'b1;
              r_inst      <= w_rd_data;
              r_hit_count <= r_hit_count + 32'd1;
            end
          end
        end
        LOOKUP: begin
          // r_ack high here means the request already hit in the previous cycle.
          if (r_ack) begin
            r_state <= IDLE;
          end else begin
            r_miss_count <= r_miss_count + 32'd1;
            r_cnt        <= '0;
            r_mem_req    <= 1'b1;
            r_mem_addr   <= {r_req_addr[31:OFF], {WW{1'b0}}, 2'b00};
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_ack) begin
            if (w_crit) r_resp <= mem_rdata;
            r_cnt <= w_next_cnt;
            if (r_cnt == LAST) begin
              r_mem_req <= 1'b0;
              r_ack     <= 1'b1;
              r_inst    <= w_crit ? mem_rdata : r_resp;
              r_state   <= RESPOND;
            end else begin
              r_mem_addr <= {r_req_addr[31:OFF], w_next_cnt, 2'b00};
            end
          end
        end
        RESPOND: begin
          r_flush_pend <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign cache_ack  = r_ack;
  assign inst       = r_inst;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a 2-cycle-latency memory that returns word = address,
// cold/hit/conflict/critical-word/flush/reset-mid-refill scenarios.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_ready = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        cache_ack;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_acks = 0;
  int ack_cyc = 0;
  int mwait  = 0;
  logic [31:0] mem_log [128];

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .addr_ready (addr_ready),
    .addr       (addr),
    .flush      (flush),
    .cache_ack  (cache_ack),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory: ack 2 cycles after the request is seen, one ack per word, data = address.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        mwait   = 0;
      end else if (!mem_req) begin
        mwait = 0;
      end else begin
        mwait++;
        if (mwait == 2) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr;
          if (n_acks < 128) mem_log[n_acks] = mem_addr;
          n_acks++;
          ack_cyc = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (cache_ack) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic access(input string tag, input logic [31:0] a, input logic fl, input bit miss);
    int base;
    int at;
    int rc;
    base = n_acks;
    @(negedge clk);
    addr = a; addr_ready = 1'b1; flush = fl; rc = cyc;
    @(negedge clk);
    addr_ready = 1'b0; flush = 1'b0;
    wait_ack(at);
    check({tag, " inst"}, inst, a);
    check({tag, " mem_req at ack"}, 32'(mem_req), 32'd0);
    if (miss) begin
      check({tag, " words fetched"}, 32'(n_acks - base), 32'd4);
      check({tag, " ack cycle"}, 32'(at), 32'(ack_cyc + 1));
      for (int w = 0; w < 4; w++)
        check({tag, " mem_addr"}, mem_log[(base + w) % 128], (a & ~32'hF) + 32'(w * 4));
    end else begin
      check({tag, " words fetched"}, 32'(n_acks - base), 32'd0);
      check({tag, " ack cycle"}, 32'(at), 32'(rc + 1));
    end
    @(negedge clk);
    check({tag, " ack pulse"}, 32'(cache_ack), 32'd0);
  endtask

  initial begin
    int base;
    int at;
    int stray;

    repeat (3) @(negedge clk);
    check("reset cache_ack", 32'(cache_ack), 32'd0);
    check("reset inst", inst, 32'h0000_0013);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
    rst = 1'b0;

    access("cold 0x100", 32'h100, 1'b0, 1'b1);
    check("cold miss_count", miss_count, 32'd1);
    access("hit 0x108", 32'h108, 1'b0, 1'b0);
    check("hit hit_count", hit_count, 32'd1);
    check("hit miss_count", miss_count, 32'd1);

    access("conflict 0x200", 32'h200, 1'b0, 1'b1);
    access("conflict 0x100", 32'h100, 1'b0, 1'b1);
    check("conflict miss_count", miss_count, 32'd3);

    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    access("critical 0x10C", 32'h10C, 1'b0, 1'b1);
    check("critical miss_count", miss_count, 32'd4);

    // Flush pulse while the 0x300 line is being refilled.
    base = n_acks;
    @(negedge clk); addr = 32'h300; addr_ready = 1'b1;
    @(negedge clk); addr_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_acks > base) break;
      @(negedge clk);
    end
    check("refill flush started", 32'(mem_req), 32'd1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_ack(at);
    check("refill flush ack cycle", 32'(at), 32'(ack_cyc + 1));
    check("refill flush inst", inst, 32'h300);
    check("refill flush words", 32'(n_acks - base), 32'd4);
    check("refill flush miss_count", miss_count, 32'd5);
    @(negedge clk);

    access("refetch 0x300", 32'h300, 1'b0, 1'b1);
    access("hit 0x304", 32'h304, 1'b0, 1'b0);
    check("hit 0x304 hit_count", hit_count, 32'd2);
    access("flush+req 0x308", 32'h308, 1'b1, 1'b1);
    check("flush+req miss_count", miss_count, 32'd7);

    // Reset arriving just after the second word of a refill.
    base = n_acks;
    @(negedge clk); addr = 32'h500; addr_ready = 1'b1;
    @(negedge clk); addr_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (n_acks >= base + 2) break;
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midreset mem_req", 32'(mem_req), 32'd0);
    check("midreset cache_ack", 32'(cache_ack), 32'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cache_ack) stray++;
    end
    check("midreset stray acks", 32'(stray), 32'd0);
    check("midreset words", 32'(n_acks - base), 32'd2);
    check("midreset miss_count", miss_count, 32'd0);
    check("midreset hit_count", hit_count, 32'd0);
    access("after reset 0x500", 32'h500, 1'b0, 1'b1);
    check("after reset miss_count", miss_count, 32'd1);
    check("after reset hit_count", hit_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
